mfp_input_debounce_irq: RTL
===========================

// Module: mfp_input_debounce_irq
// PURPOSE
//  Parametrised successor to the 2-channel switch/button sync+debouncer: N channels of
//  2-flop sync + debounce, per-channel rise/fall edge detect, sticky pending bits and a
//  masked interrupt line. Sits between board pins (SW, BTN*) and mfp_sys GPIO/interrupt
//  logic. Feeds the CPU hardware interrupt used by the interrupts lab.
// PARAMETERS
//  WIDTH            16       number of input channels (>=1)
//  DEBOUNCE_CYCLES  500000   cycles the synced input must be stable before accepted (>=1)
//  RESET_LEVEL      1'b0     debounced level loaded on reset (all channels)
// PORTS
//  SI_ClkIn      in   1      system clock; all flops on rising edge
//  SI_Reset_N    in   1      asynchronous active-low reset
//  raw_in        in   WIDTH  asynchronous pin inputs (switches/buttons)
//  rise_en       in   WIDTH  per-channel: rising debounced edge sets pending
//  fall_en       in   WIDTH  per-channel: falling debounced edge sets pending
//  irq_mask      in   WIDTH  per-channel interrupt enable
//  clr_we        in   1      write strobe for pending clear
//  clr_bits      in   WIDTH  write-1-to-clear mask for pending (valid with clr_we)
//  db_out        out  WIDTH  debounced level
//  edge_pulse    out  WIDTH  1-cycle pulse on any accepted debounced transition
//  pending       out  WIDTH  sticky event flags
//  irq           out  1      registered OR of (pending & irq_mask)
// BEHAVIOUR
//  - One clock (SI_ClkIn); reset is asynchronous, active-low (SI_Reset_N). On reset: sync flops and
//    db_out = {WIDTH{RESET_LEVEL}}, counters 0, edge_pulse 0, pending 0, irq 0.
//  - Sync: s1<=raw_in, s2<=s1 per channel (2 cycles).
//  - Debounce, per channel, each edge: if s2==db: cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1:
//    db<=s2, cnt<=0, edge_pulse<=1. Else cnt<=cnt+1. edge_pulse is 0 on all other cycles.
//  - Latency: raw change held stable -> db_out changes exactly 2+DEBOUNCE_CYCLES edges later.
//  - Glitch: any excursion that returns to db before the count completes resets cnt; no
//    db change, no pulse. Counter width $clog2(DEBOUNCE_CYCLES+1); never wraps.
//  - Pending: set_i = accepted transition & ((new==1 & rise_en) | (new==0 & fall_en)),
//    applied on the same edge db_out updates. clear_i = clr_we & clr_bits.
//    pending <= (pending & ~clear_i) | set_i : simultaneous set and clear -> set wins.
//  - Enables are sampled at the update edge; changing rise_en/fall_en never sets or clears
//    pending by itself. Clearing a bit already 0 has no effect.
//  - irq <= |(pending & irq_mask); asserts 1 cycle after pending/mask make it true,
//    deasserts 1 cycle after clear or mask-off. Level, not pulse.
//  - Reset asserted mid-count or with pending set: all state cleared immediately; after
//    release the first acceptance again needs full 2+DEBOUNCE_CYCLES.
//  - Channels fully independent; no priority encoding.
// STRUCTURE
//  - Default DEBOUNCE_CYCLES and simulation override macro live in mfp_config.vh
//    (alongside MFP_USE_SLOW_CLOCK); no other shared constants.
//  - Sub-module mfp_sync_debounce_channel (sync, counter, db flop, edge_pulse) instantiated
//    WIDTH times via generate; pending/irq logic stays in this module.
// TESTING  (WIDTH=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=0)
//  1 raw_in[0] 0->1 held -> db_out[0]=1 and edge_pulse[0]=1 exactly 6 edges later; pulse 1 cycle.
//  2 raw_in[1] 3-cycle high glitch then low -> db_out[1], edge_pulse[1], pending[1] stay 0.
//  3 rise_en=4'b0001, fall_en=0, mask=4'b0001; ch0 rises -> pending=0001, irq=1 one cycle
//    later; ch0 falls -> pending unchanged; clr_we with clr_bits=0001 -> pending=0, irq=0 next.
//  4 clr_we/clr_bits=0010 on same edge ch1 rising event sets pending[1] (rise_en[1]=1)
//    -> pending[1]=1 (set wins).
//  5 pending=0100, mask=0 -> irq=0; set mask[2]=1 -> irq=1 next edge; mask off -> irq=0.
//  6 SI_Reset_N low mid-count (cnt=2) with pending=1111 -> all outputs 0 asynchronously;
//    after release held input accepted only after full 6 edges.

Source files
------------

// File: rtl/mfp_input_debounce_irq_pkg.sv
//-----------------------------------------------------------------------------
// mfp_input_debounce_irq_pkg
//
// Shared constants and small helpers for the input debounce / interrupt block.
//
// Contents:
//   DEBOUNCE_CYCLES_DEFAULT  default stability window in clock cycles. The
//                            board default is 500000 cycles.
//   WIDTH_DEFAULT            default channel count.
//   cnt_width()              width of a counter that holds 0..cycles.
//   event_set()              decides whether an accepted transition on one
//                            channel raises its pending flag.
//-----------------------------------------------------------------------------
package mfp_input_debounce_irq_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    localparam int unsigned WIDTH_DEFAULT = 16;

    // Counter width able to hold DEBOUNCE_CYCLES. The counter stops at
    // DEBOUNCE_CYCLES-1, so it can never wrap.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

    // A rising acceptance sets pending when rise_en is set. A falling
    // acceptance sets pending when fall_en is set.
    function automatic logic event_set(input logic accept,
                                       input logic new_level,
                                       input logic rise_en,
                                       input logic fall_en);
        return accept & (new_level ? rise_en : fall_en);
    endfunction

endpackage

// File: rtl/mfp_sync_debounce_channel.sv
//-----------------------------------------------------------------------------
// mfp_sync_debounce_channel
//
// One input channel. It has a 2-flop synchroniser, followed by a stability
// counter and the debounced level flop. The synchronised input must differ
// from the current debounced level for DEBOUNCE_CYCLES consecutive edges.
// Only then is the new level accepted. Any return to the current level
// before that restarts the count.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   raw         in   asynchronous pin input
//   db          out  debounced level (registered)
//   edge_pulse  out  1-cycle pulse, registered, on the edge db changes
//   accept      out  combinational: db takes new_level on the coming edge
//   new_level   out  combinational: level that db will take on acceptance
//-----------------------------------------------------------------------------
module mfp_sync_debounce_channel
    import mfp_input_debounce_irq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic edge_pulse,
    output logic accept,
    output logic new_level
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // The synchroniser flops reset to RESET_LEVEL. This keeps the first
    // post-reset comparisons against db quiet.
    // NOTE: sequential state uses non-blocking assignments. This way s2 samples
    // the old s1, which gives a true two-stage pipeline. It also avoids a
    // simulation race with the debounce logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RESET_LEVEL;
            s2 <= RESET_LEVEL;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign accept    = (s2 != db) && (cnt == CNT_LAST);
    assign new_level = s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db         <= RESET_LEVEL;
            cnt        <= '0;
            edge_pulse <= 1'b0;
        end else begin
            edge_pulse <= 1'b0;
            if (s2 == db) begin
                // The input agrees with the accepted level. A glitch that
                // returns here forfeits any partial count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db         <= s2;
                cnt        <= '0;
                edge_pulse <= 1'b1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mfp_input_debounce_irq.sv
//-----------------------------------------------------------------------------
// mfp_input_debounce_irq
//
// This block debounces WIDTH switch/button inputs. It sits between the board
// pins and the mfp_sys GPIO/interrupt logic. Each channel is synchronised and
// debounced by its own mfp_sync_debounce_channel. This module holds the
// sticky pending flags and the masked interrupt line that feeds the CPU.
//
// Ports:
//   SI_ClkIn    in   system clock, rising edge
//   SI_Reset_N  in   asynchronous active-low reset
//   raw_in      in   [WIDTH] asynchronous pin inputs
//   rise_en     in   [WIDTH] a rising debounced edge sets pending
//   fall_en     in   [WIDTH] a falling debounced edge sets pending
//   irq_mask    in   [WIDTH] per-channel interrupt enable
//   clr_we      in   write strobe for the pending clear
//   clr_bits    in   [WIDTH] write-1-to-clear mask, qualified by clr_we
//   db_out      out  [WIDTH] debounced levels
//   edge_pulse  out  [WIDTH] 1-cycle pulse on each accepted transition
//   pending     out  [WIDTH] sticky event flags
//   irq         out  registered OR of (pending & irq_mask)
//-----------------------------------------------------------------------------
module mfp_input_debounce_irq
    import mfp_input_debounce_irq_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset_N,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic             clr_we,
    input  logic [WIDTH-1:0] clr_bits,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] edge_pulse,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] new_level;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] clear_vec;
    logic [WIDTH-1:0] pending_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        mfp_sync_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_chan (
            .clk        (SI_ClkIn),
            .rst_n      (SI_Reset_N),
            .raw        (raw_in[i]),
            .db         (db_out[i]),
            .edge_pulse (edge_pulse[i]),
            .accept     (accept[i]),
            .new_level  (new_level[i])
        );
    end

    // Events are taken from the channel's accept strobe, not from edge_pulse.
    // The accept strobe lets pending update on the same edge as db_out.
    // The enables are sampled only at that edge, so toggling an enable on its
    // own never changes pending.
    // NOTE: every signal assigned in always_comb gets a default first. This
    // way no path leaves it unassigned, and no latch is inferred.
    always_comb begin
        set_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_vec[i] = event_set(accept[i], new_level[i], rise_en[i], fall_en[i]);
        end
        clear_vec    = clr_we ? clr_bits : '0;
        // The set term is ORed in last, so a simultaneous set overrides a clear.
        pending_next = (pending & ~clear_vec) | set_vec;
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= pending_next;
            // The registered pending is used here, so irq follows pending
            // (or a mask change) by one cycle.
            irq     <= |(pending & irq_mask);
        end
    end

endmodule
